fetch_queue: RTL and testbench
==============================

# fetch_queue

Dual-issue in-order instruction queue between the fetch stage (instruction memory, Gshare/loop-detector prediction) and the 2-wide decoder. It accepts up to two instructions per cycle with their PCs and prediction bits, and delivers up to two per cycle in program order. It decouples fetch from decode and issue stalls, and is emptied in one cycle on a branch correction.

## Interface
Parameters:
- WIDTH, 32, instruction/PC width
- DEPTH, 8, entry count; power of two, ≥4
- PTR, $clog2(DEPTH), pointer width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  branch correction / jump redirect; empties the queue
- enq_valid  in  2  fetch slot valid; slot 0 is older; legal patterns 00, 01, 11
- enq_inst  in  2×WIDTH  fetched instructions, [0] older
- enq_pc  in  WIDTH  PC of slot 0; slot 1 PC is enq_pc+4
- enq_bp_taken  in  2  per-slot predicted-taken bit
- enq_ready  out  1  high when free entries ≥ 2
- deq_valid  out  2  decode slot valid; [0] = count≥1, [1] = count≥2
- deq_inst  out  2×WIDTH  head and head+1 instructions
- deq_pc  out  2×WIDTH  their PCs
- deq_bp_taken  out  2  their prediction bits
- deq_ready  in  2  decode accept; legal patterns 00, 01, 11
- count  out  PTR+1  occupied entries

## Operation
- Circular buffer with registered head, tail (PTR bits, wrap mod DEPTH) and count (PTR+1 bits, 0..DEPTH).
- Enqueue fires only when enq_ready=1.
  - n_enq = number of accepted slots.
  - If enq_bp_taken[0]=1 and enq_valid=11, slot 1 is discarded (it follows a predicted-taken branch), so n_enq=1.
  - Slot 0 is written at tail, slot 1 at tail+1; tail advances by n_enq.
- Dequeue: n_deq = popcount(deq_valid & deq_ready); head advances by n_deq.
- count_next = count + n_enq − n_deq. Simultaneous enqueue and dequeue are both honoured.
- enq_ready is computed from registered count only (DEPTH−count ≥ 2) and ignores same-cycle dequeue. This is a conservative rule with no combinational path from deq_ready.
- Illegal enq_valid=10 is treated as 00. Illegal deq_ready=10 is treated as 00. Both raise a simulation assertion.
- flush has highest priority. Next cycle head=tail=count=0. Same-cycle enqueue and dequeue are discarded.
- Storage is not reset. Dequeue outputs are don't-care where deq_valid is low.

## Timing
- Reset: count=0, head=tail=0, deq_valid=00, enq_ready=1.
- Latency: an entry enqueued in cycle N appears on deq_* in cycle N+1. There is no same-cycle bypass.
- deq_* are combinational reads of the registered head/head+1 entries.
- Boundaries:
  - count=DEPTH−1: enq_ready=0, even if decode dequeues in that cycle.
  - count=1: deq_valid=01. deq_ready=11 dequeues one entry only.
  - head+1 wraps from DEPTH−1 to 0.
  - flush with reset asserted: reset wins, with an identical result.
  - flush while empty: no effect.

## Structure
- Shared core package:
  - typedef fetch_entry_t {inst[WIDTH], pc[WIDTH], bp_taken}
  - DEPTH default constant
- Sub-module fetch_queue_ram: DEPTH×fetch_entry_t, 2 write ports and 2 asynchronous read ports, no reset.
- The top level holds the pointers, count, accept logic and assertions.

## Test plan
- Reset, then 4 cycles of enq_valid=11 from PC 0x0 with deq_ready=00 → count=8; enq_ready drops to 0 once count reaches 7. deq_pc[0]=0x0, deq_pc[1]=0x4.
- Fill to 8, then deq_ready=11 for 4 cycles → PCs 0x0..0x1C in order; count reaches 0; deq_valid=00.
- Steady state enq=11 and deq=11 with count=2 → count holds at 2 while pointers wrap past DEPTH−1; order is preserved.
- enq_valid=11 at PC 0x40 with enq_bp_taken=01 → count+1; only 0x40 is queued.
- count=5, then flush together with enq_valid=11 → next cycle count=0, deq_valid=00, enq_ready=1. The enqueued pair is dropped.
- count=1 with deq_ready=11 and enq_valid=01 in the same cycle → count stays 1; the new entry is at head next cycle.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the dual-issue fetch queue.
package fetch_queue_pkg;

   localparam int unsigned FQ_WIDTH = 32;
   localparam int unsigned FQ_DEPTH = 8;

   typedef struct packed {
      logic [FQ_WIDTH-1:0] inst;
      logic [FQ_WIDTH-1:0] pc;
      logic                bp_taken;
   } fetch_entry_t;

   // Only 00, 01 and 11 are legal two-slot patterns; 10 collapses to 00.
   function automatic logic [1:0] slot_mask(input logic [1:0] v);
      return (v == 2'b10) ? 2'b00 : v;
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle of the fetch queue.
interface fetch_queue_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned PTR   = $clog2(DEPTH)
) ();

   logic                  flush;
   logic [1:0]            enq_valid;
   logic [1:0][WIDTH-1:0] enq_inst;
   logic [WIDTH-1:0]      enq_pc;
   logic [1:0]            enq_bp_taken;
   logic                  enq_ready;
   logic [1:0]            deq_valid;
   logic [1:0][WIDTH-1:0] deq_inst;
   logic [1:0][WIDTH-1:0] deq_pc;
   logic [1:0]            deq_bp_taken;
   logic [1:0]            deq_ready;
   logic [PTR:0]          count;

   modport master (
      output flush, enq_valid, enq_inst, enq_pc, enq_bp_taken, deq_ready,
      input  enq_ready, deq_valid, deq_inst, deq_pc, deq_bp_taken, count
   );

   modport slave (
      input  flush, enq_valid, enq_inst, enq_pc, enq_bp_taken, deq_ready,
      output enq_ready, deq_valid, deq_inst, deq_pc, deq_bp_taken, count
   );

endinterface

// File: rtl/fetch_queue_ram.sv
// Entry storage: two write ports, two asynchronous read ports, no reset.
module fetch_queue_ram
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = FQ_DEPTH,
   parameter int unsigned PTR   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         we0,
   input  logic [PTR-1:0] waddr0,
   input  fetch_entry_t wdata0,
   input  logic         we1,
   input  logic [PTR-1:0] waddr1,
   input  fetch_entry_t wdata1,
   input  logic [PTR-1:0] raddr0,
   output fetch_entry_t rdata0,
   input  logic [PTR-1:0] raddr1,
   output fetch_entry_t rdata1
);

   fetch_entry_t mem [DEPTH];

   // The two write addresses are always tail and tail+1, so never equal.
   always_ff @(posedge clk) begin
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
   end

   assign rdata0 = mem[raddr0];
   assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue in-order instruction queue between fetch and the 2-wide decoder.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned WIDTH = FQ_WIDTH, // storage entries are sized by FQ_WIDTH
   parameter int unsigned DEPTH = FQ_DEPTH,
   parameter int unsigned PTR   = $clog2(DEPTH)
) (
   input logic          clk,
   input logic          rst,
   fetch_queue_if.slave bus
);

   logic [PTR-1:0] head_q, tail_q;
   logic [PTR:0]   count_q;
   logic [1:0]     enq_v, deq_r, take;
   logic [1:0]     n_enq, n_deq;
   logic           enq_ready, we0, we1;
   fetch_entry_t   wdata0, wdata1, rdata0, rdata1;

   assign enq_v = slot_mask(bus.enq_valid);
   assign deq_r = slot_mask(bus.deq_ready);

   // Conservative: based on registered count only, no path from deq_ready.
   assign enq_ready = (count_q <= (PTR+1)'(DEPTH - 2));

   // Slot 1 is dropped when slot 0 is a predicted-taken branch.
   assign we0   = enq_ready & enq_v[0] & ~bus.flush;
   assign we1   = we0 & enq_v[1] & ~bus.enq_bp_taken[0];
   assign n_enq = {1'b0, we0} + {1'b0, we1};

   assign take  = bus.deq_valid & deq_r;
   assign n_deq = {1'b0, take[0]} + {1'b0, take[1]};

   always_comb begin
      wdata0 = '{inst: bus.enq_inst[0], pc: bus.enq_pc, bp_taken: bus.enq_bp_taken[0]};
      wdata1 = '{inst: bus.enq_inst[1], pc: bus.enq_pc + WIDTH'(4),
                 bp_taken: bus.enq_bp_taken[1]};
   end

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_q + PTR'(n_deq);
         tail_q  <= tail_q + PTR'(n_enq);
         count_q <= count_q + (PTR+1)'(n_enq) - (PTR+1)'(n_deq);
      end
   end

   fetch_queue_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk    (clk),
      .we0    (we0),
      .waddr0 (tail_q),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (tail_q + PTR'(1)),
      .wdata1 (wdata1),
      .raddr0 (head_q),
      .rdata0 (rdata0),
      .raddr1 (head_q + PTR'(1)),
      .rdata1 (rdata1)
   );

   always_comb begin
      bus.enq_ready       = enq_ready;
      bus.count           = count_q;
      bus.deq_valid       = {count_q >= (PTR+1)'(2), count_q != '0};
      bus.deq_inst[0]     = rdata0.inst;
      bus.deq_inst[1]     = rdata1.inst;
      bus.deq_pc[0]       = rdata0.pc;
      bus.deq_pc[1]       = rdata1.pc;
      bus.deq_bp_taken[0] = rdata0.bp_taken;
      bus.deq_bp_taken[1] = rdata1.bp_taken;
   end

   a_enq_legal : assert property (@(posedge clk) disable iff (rst) bus.enq_valid != 2'b10)
      else $error("fetch_queue: illegal enq_valid pattern 10");
   a_deq_legal : assert property (@(posedge clk) disable iff (rst) bus.deq_ready != 2'b10)
      else $error("fetch_queue: illegal deq_ready pattern 10");

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench: queue-based reference model plus directed and random traffic.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 8;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        bp;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;
   bit   started = 0;
   ent_t mq[$];

   always #5 clk = ~clk;

   fetch_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fq ();

   fetch_queue #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (fq)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue updated with the accept rules at each clock edge.
   always @(posedge clk) begin
      int   sz;
      int   n_d;
      bit   room;
      ent_t e;
      started = 1;
      if (rst || fq.flush) begin
         mq.delete();
      end else begin
         sz   = mq.size();
         room = (DEPTH - sz) >= 2;
         case (fq.deq_ready)
            2'b11:   n_d = (sz < 2) ? sz : 2;
            2'b01:   n_d = (sz < 1) ? sz : 1;
            default: n_d = 0;
         endcase
         repeat (n_d) void'(mq.pop_front());
         if (room && (fq.enq_valid == 2'b01 || fq.enq_valid == 2'b11)) begin
            e = '{inst: fq.enq_inst[0], pc: fq.enq_pc, bp: fq.enq_bp_taken[0]};
            mq.push_back(e);
            if (fq.enq_valid == 2'b11 && !fq.enq_bp_taken[0]) begin
               e = '{inst: fq.enq_inst[1], pc: fq.enq_pc + 32'd4, bp: fq.enq_bp_taken[1]};
               mq.push_back(e);
            end
         end
      end
   end

   // Compare process: mid-cycle, every cycle once the first edge has been seen.
   always @(negedge clk) begin
      if (started) begin
         chk("count", fq.count, mq.size());
         chk("enq_ready", fq.enq_ready, (DEPTH - mq.size()) >= 2);
         chk("deq_valid", fq.deq_valid, {mq.size() >= 2, mq.size() >= 1});
         for (int i = 0; i < 2; i++) begin
            if (i < mq.size()) begin
               chk("deq_inst", fq.deq_inst[i], mq[i].inst);
               chk("deq_pc", fq.deq_pc[i], mq[i].pc);
               chk("deq_bp", fq.deq_bp_taken[i], mq[i].bp);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] ev, input logic [1:0] dr, input logic [31:0] pc,
                        input logic [1:0] bp, input logic fl);
      fq.enq_valid    = ev;
      fq.deq_ready    = dr;
      fq.enq_pc       = pc;
      fq.enq_bp_taken = bp;
      fq.flush        = fl;
      fq.enq_inst[0]  = $urandom;
      fq.enq_inst[1]  = $urandom;
   endtask

   function automatic logic [1:0] pick(input int unsigned heavy);
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < heavy) return 2'b11;
      if (r < heavy + 2) return 2'b01;
      return 2'b00;
   endfunction

   initial begin
      rst = 1'b1;
      drive(2'b00, 2'b00, 32'h0, 2'b00, 1'b0);
      cyc();
      cyc();
      chk("reset_count", fq.count, 0);
      chk("reset_enq_ready", fq.enq_ready, 1);
      chk("reset_deq_valid", fq.deq_valid, 2'b00);
      rst = 1'b0;

      // Fill with four pairs from PC 0.
      for (int k = 0; k < 4; k++) begin
         drive(2'b11, 2'b00, 32'(k * 8), 2'b00, 1'b0);
         cyc();
         if (k == 2) chk("fill_ready_at_6", fq.enq_ready, 1);
      end
      drive(2'b00, 2'b00, 32'h0, 2'b00, 1'b0);
      chk("fill_count", fq.count, 8);
      chk("fill_enq_ready", fq.enq_ready, 0);
      chk("fill_pc0", fq.deq_pc[0], 32'h0);
      chk("fill_pc1", fq.deq_pc[1], 32'h4);

      // Drain two per cycle.
      for (int k = 0; k < 4; k++) begin
         chk("drain_pc0", fq.deq_pc[0], 32'(k * 8));
         drive(2'b00, 2'b11, 32'h0, 2'b00, 1'b0);
         cyc();
      end
      chk("drain_count", fq.count, 0);
      chk("drain_deq_valid", fq.deq_valid, 2'b00);

      // Steady state: pointers wrap with count holding at 2.
      drive(2'b11, 2'b00, 32'h80, 2'b00, 1'b0);
      cyc();
      for (int k = 1; k <= 12; k++) begin
         drive(2'b11, 2'b11, 32'h80 + 32'(k * 8), 2'b00, 1'b0);
         cyc();
      end
      chk("steady_count", fq.count, 2);
      chk("steady_pc0", fq.deq_pc[0], 32'hE0);

      // Predicted-taken slot 0 drops slot 1.
      drive(2'b11, 2'b00, 32'h40, 2'b01, 1'b0);
      cyc();
      chk("bp_count", fq.count, 3);

      // Drain, build up to 5, then flush with a same-cycle enqueue.
      drive(2'b00, 2'b11, 32'h0, 2'b00, 1'b0);
      cyc();
      cyc();
      drive(2'b11, 2'b00, 32'h300, 2'b00, 1'b0);
      cyc();
      drive(2'b11, 2'b00, 32'h308, 2'b00, 1'b0);
      cyc();
      drive(2'b01, 2'b00, 32'h310, 2'b00, 1'b0);
      cyc();
      chk("pre_flush_count", fq.count, 5);
      drive(2'b11, 2'b11, 32'h400, 2'b00, 1'b1);
      cyc();
      drive(2'b00, 2'b00, 32'h0, 2'b00, 1'b0);
      chk("flush_count", fq.count, 0);
      chk("flush_deq_valid", fq.deq_valid, 2'b00);
      chk("flush_enq_ready", fq.enq_ready, 1);

      // count=1, deq 11 with enq 01: one out, one in.
      drive(2'b01, 2'b00, 32'h100, 2'b00, 1'b0);
      cyc();
      drive(2'b01, 2'b11, 32'h200, 2'b00, 1'b0);
      cyc();
      chk("one_count", fq.count, 1);
      chk("one_head_pc", fq.deq_pc[0], 32'h200);

      // Reset and flush together.
      drive(2'b11, 2'b00, 32'h500, 2'b00, 1'b0);
      cyc();
      rst = 1'b1;
      drive(2'b11, 2'b01, 32'h600, 2'b00, 1'b1);
      cyc();
      rst = 1'b0;
      drive(2'b00, 2'b00, 32'h0, 2'b00, 1'b0);
      chk("rst_flush_count", fq.count, 0);

      // Randomized traffic with alternating fill/drain bias.
      for (int i = 0; i < 3000; i++) begin
         int unsigned eh, dh;
         eh = ((i / 150) % 2 == 0) ? 6 : 2;
         dh = ((i / 150) % 2 == 0) ? 2 : 6;
         drive(pick(eh), pick(dh), {$urandom} & 32'hFFFF_FFFC, 2'($urandom),
               ($urandom_range(0, 39) == 0));
         cyc();
      end

      drive(2'b00, 2'b00, 32'h0, 2'b00, 1'b0);
      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
